// File: rtl/inert_seq.sv
// SPI sequencer for the inertial sensor: power-up wait, four configuration writes,
// then a six-byte pitch/roll/yaw read burst for every data-ready INT.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// PWR      | sensor power-up wait, counter runs to terminal count
// CFG_REQ  | issue one configuration write (wrt pulse)
// CFG_WAIT | configuration write in flight, wait for done
// IDLE     | configured, wait for synchronised INT
// RD_REQ   | issue one data-byte read (wrt pulse)
// RD_WAIT  | data read in flight, wait for done and capture the byte
// VLD      | publish all six bytes and strobe vld
module inert_seq #(
  parameter int PWR_W = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        INT,
  input  logic        done,
  input  logic [15:0] rd_data,
  output logic        wrt,
  output logic [15:0] wt_data,
  output logic        cfg_done,
  output logic [15:0] ptch,
  output logic [15:0] roll,
  output logic [15:0] yaw,
  output logic        vld
);

  typedef enum logic [2:0] {
    PWR, CFG_REQ, CFG_WAIT, IDLE, RD_REQ, RD_WAIT, VLD
  } state_t;

  state_t             state, state_nxt;
  logic [PWR_W-1:0]   pwr_cnt;
  logic [1:0]         cfg_idx;
  logic [2:0]         rd_idx;
  logic [7:0]         hold_b [0:5];
  logic               int_ff1, int_ff2;
  logic               pwr_tc;
  logic [14:0]        cfg_frame;
  logic [15:0]        rd_frame;

  assign pwr_tc   = &pwr_cnt;
  assign rd_frame = {1'b1, 7'h22 + {4'd0, rd_idx}, 8'h00};

  // {addr[6:0], value[7:0]}; entry 0 routes data-ready onto the INT pin
  always_comb begin
    cfg_frame = 15'h0;
    case (cfg_idx)
      2'd0: cfg_frame = {7'h0D, 8'h02};
      2'd1: cfg_frame = {7'h10, 8'h62};
      2'd2: cfg_frame = {7'h11, 8'h4C};
      2'd3: cfg_frame = {7'h14, 8'h60};
      default: cfg_frame = 15'h0;
    endcase
  end

  always_comb begin
    state_nxt = state;
    wrt       = 1'b0;
    wt_data   = 16'h0000;
    case (state)
      PWR:      if (pwr_tc) state_nxt = CFG_REQ;
      CFG_REQ: begin
        wrt       = 1'b1;
        wt_data   = {1'b0, cfg_frame};
        state_nxt = CFG_WAIT;
      end
      CFG_WAIT: begin
        wt_data = {1'b0, cfg_frame};
        if (done) state_nxt = (cfg_idx == 2'd3) ? IDLE : CFG_REQ;
      end
      IDLE:     if (int_ff2) state_nxt = RD_REQ;
      RD_REQ: begin
        wrt       = 1'b1;
        wt_data   = rd_frame;
        state_nxt = RD_WAIT;
      end
      RD_WAIT: begin
        wt_data = rd_frame;
        if (done) state_nxt = (rd_idx == 3'd5) ? VLD : RD_REQ;
      end
      VLD:      state_nxt = IDLE;
      default:  state_nxt = PWR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= PWR;
      pwr_cnt  <= '0;
      cfg_idx  <= 2'd0;
      rd_idx   <= 3'd0;
      int_ff1  <= 1'b0;
      int_ff2  <= 1'b0;
      cfg_done <= 1'b0;
      ptch     <= 16'h0000;
      roll     <= 16'h0000;
      yaw      <= 16'h0000;
      vld      <= 1'b0;
      for (int i = 0; i < 6; i++) hold_b[i] <= 8'h00;
    end else begin
      state   <= state_nxt;
      int_ff1 <= INT;
      int_ff2 <= int_ff1;
      vld     <= 1'b0;
      pwr_cnt <= (state == PWR) ? pwr_cnt + 1'b1 : '0;
      case (state)
        PWR: if (pwr_tc) cfg_idx <= 2'd0;
        CFG_WAIT: if (done) begin
          if (cfg_idx == 2'd3) cfg_done <= 1'b1;
          else                 cfg_idx  <= cfg_idx + 2'd1;
        end
        IDLE: if (int_ff2) rd_idx <= 3'd0;
        RD_WAIT: if (done) begin
          hold_b[rd_idx] <= rd_data[7:0];
          if (rd_idx != 3'd5) rd_idx <= rd_idx + 3'd1;
        end
        // outputs move only here so a triple never mixes two bursts
        VLD: begin
          ptch <= {hold_b[1], hold_b[0]};
          roll <= {hold_b[3], hold_b[2]};
          yaw  <= {hold_b[5], hold_b[4]};
          vld  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_inert_seq.sv
// Bench for inert_seq: a small SPI/sensor responder plus a scoreboard of expected
// frames, read-back bytes and published samples, checked every cycle.
module tb_inert_seq;
  localparam int PWR_W = 10;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        done = 1'b0;
  logic [15:0] rd_data = 16'h0000;
  logic        wrt, cfg_done, vld;
  logic [15:0] wt_data, ptch, roll, yaw;

  logic int_arm = 1'b0;
  int   a2_cnt = 0;
  int   a2_clear_at = 0;
  logic int_line;
  // the sensor drops INT once the first data byte of the burst is addressed
  assign int_line = int_arm && (a2_cnt < a2_clear_at);

  int total = 0;
  int bad   = 0;

  logic [15:0] exp_frames[$];
  logic [7:0]  resp_q[$];
  logic [47:0] exp_samples[$];

  bit          pending = 0;
  int          cnt_dn = 0;
  logic [15:0] cur_frame = 16'h0;
  int          txn_no = 0;
  int          wr_done_cnt = 0;
  int          rd_done_cnt = 0;
  bit          cfg_exp = 0, cfg_pend = 0;
  bit          vp0 = 0, vp1 = 0, vld_exp = 0;
  int          spur_req = 0, spur_ack = 0;
  logic        rst_seen = 1'b0;

  inert_seq #(.PWR_W(PWR_W)) dut (
    .clk(clk), .rst(rst), .INT(int_line), .done(done), .rd_data(rd_data),
    .wrt(wrt), .wt_data(wt_data), .cfg_done(cfg_done),
    .ptch(ptch), .roll(roll), .yaw(yaw), .vld(vld)
  );

  always #5 clk = ~clk;

  always @(posedge clk) rst_seen <= rst;

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // responder + compare process
  always @(negedge clk) begin
    logic [47:0] s;
    if (rst) begin
      if (rst_seen)
        chk("reset_outputs", {wrt, wt_data, cfg_done, ptch, roll, yaw, vld}, 80'h0);
      pending = 0; done = 1'b0; cnt_dn = 0; wr_done_cnt = 0;
      cfg_exp = 0; cfg_pend = 0; vp0 = 0; vp1 = 0; vld_exp = 0;
      spur_ack = spur_req;
    end else begin
      vld_exp = vp1; vp1 = vp0; vp0 = 0;
      cfg_exp = cfg_exp | cfg_pend; cfg_pend = 0;
      done = 1'b0;
      chk("vld", vld, vld_exp);
      chk("cfg_done", cfg_done, cfg_exp);
      if (vld) begin
        if (exp_samples.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_vld: got vld=1 want no vld");
        end else begin
          s = exp_samples.pop_front();
          chk("ptch", ptch, s[47:32]);
          chk("roll", roll, s[31:16]);
          chk("yaw", yaw, s[15:0]);
        end
      end
      if (wrt) begin
        chk("wrt_overlap", pending, 0);
        if (exp_frames.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_wrt: got frame %0h want no wrt", wt_data);
        end else begin
          chk("frame", wt_data, exp_frames.pop_front());
        end
        pending   = 1;
        cur_frame = wt_data;
        cnt_dn    = 1 + (txn_no % 4);
        txn_no++;
        if (wt_data == 16'hA200) a2_cnt++;
      end else if (pending) begin
        cnt_dn--;
        if (cnt_dn == 0) begin
          pending = 0;
          done    = 1'b1;
          if (cur_frame[15]) begin
            rd_data = {8'($urandom()), (resp_q.size() != 0) ? resp_q.pop_front() : 8'h00};
            rd_done_cnt++;
            if (cur_frame[14:8] == 7'h27) vp0 = 1;
          end else begin
            rd_data = {8'($urandom()), 8'($urandom())};
            wr_done_cnt++;
            if (wr_done_cnt == 4) cfg_pend = 1;
          end
        end
      end else if (spur_req != spur_ack) begin
        done     = 1'b1;
        spur_ack = spur_req;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic reset_and_config();
    int n;
    rst = 1'b1;
    int_arm = 1'b0;
    exp_frames.delete();
    exp_samples.delete();
    resp_q.delete();
    tick(3);
    exp_frames.push_back(16'h0D02);
    exp_frames.push_back(16'h1062);
    exp_frames.push_back(16'h114C);
    exp_frames.push_back(16'h1460);
    rst = 1'b0;
    n = 0;
    while (n < 2000) begin
      @(negedge clk);
      n++;
      if (wrt) break;
    end
    chk("first_wrt_delay", n, 1024);
    chk("first_frame", wt_data, 16'h0D02);
    n = 0;
    while (!cfg_done && n < 500) begin
      tick(1);
      n++;
    end
    chk("cfg_done_rise", cfg_done, 1);
    chk("cfg_frames_used", exp_frames.size(), 0);
    tick(2);
  endtask

  task automatic push_burst(input logic [47:0] s);
    for (int a = 0; a < 6; a++) exp_frames.push_back({1'b1, 7'(7'h22 + a), 8'h00});
    resp_q.push_back(s[39:32]);
    resp_q.push_back(s[47:40]);
    resp_q.push_back(s[23:16]);
    resp_q.push_back(s[31:24]);
    resp_q.push_back(s[7:0]);
    resp_q.push_back(s[15:8]);
    exp_samples.push_back(s);
  endtask

  task automatic wait_vld();
    int n;
    n = 0;
    while (!vld && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("vld_timeout", vld, 1);
  endtask

  task automatic one_sample(input logic [47:0] s);
    push_burst(s);
    a2_clear_at = a2_cnt + 1;
    int_arm = 1'b1;
    wait_vld();
    int_arm = 1'b0;
    tick(4);
  endtask

  initial begin
    logic [47:0] s;
    int base, n;

    reset_and_config();

    // directed samples with literal expectations
    push_burst(48'h1234_5678_9ABC);
    a2_clear_at = a2_cnt + 1;
    int_arm = 1'b1;
    wait_vld();
    int_arm = 1'b0;
    chk("lit_ptch", ptch, 16'h1234);
    chk("lit_roll", roll, 16'h5678);
    chk("lit_yaw", yaw, 16'h9ABC);
    tick(4);
    one_sample(48'hFFFF_0000_8001);
    chk("lit_yaw2", yaw, 16'h8001);

    for (int i = 0; i < 6; i++) begin
      s = {16'($urandom()), 16'($urandom()), 16'($urandom())};
      one_sample(s);
    end

    // INT held high across two bursts: back-to-back with no idle dwell
    push_burst(48'hA1A2_B1B2_C1C2);
    push_burst(48'h0102_0304_0506);
    a2_clear_at = a2_cnt + 2;
    int_arm = 1'b1;
    wait_vld();
    chk("hold_first_ptch", ptch, 16'hA1A2);
    @(negedge clk);
    chk("hold_no_dwell_wrt", wrt, 1);
    wait_vld();
    int_arm = 1'b0;
    chk("hold_second_yaw", yaw, 16'h0506);
    tick(60);
    chk("hold_frames_used", exp_frames.size(), 0);

    // spurious done while idle must change nothing
    spur_req++;
    tick(6);
    chk("spur_outputs", {ptch, roll, yaw}, 48'h0102_0304_0506);
    chk("spur_cfg_done", cfg_done, 1);

    // reset after the third read of a burst, then full restart
    push_burst(48'hDEAD_BEEF_CAFE);
    a2_clear_at = a2_cnt + 1;
    int_arm = 1'b1;
    base = rd_done_cnt;
    n = 0;
    while (rd_done_cnt < base + 3 && n < 400) begin
      tick(1);
      n++;
    end
    chk("midburst_reach", rd_done_cnt >= base + 3, 1);
    tick(1);
    reset_and_config();
    one_sample(48'h5A5A_0FF0_1357);
    chk("restart_roll", roll, 16'h0FF0);

    tick(10);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
